// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline control: forwarding select encodings,
// Tuse/Tnew constants, multiply/divide latencies and the stage shadow record.
package mips_pkg;

    // D-stage operand select
    localparam logic [1:0] FW_RF = 2'd0;
    localparam logic [1:0] FW_E  = 2'd1;
    localparam logic [1:0] FW_M  = 2'd2;
    localparam logic [1:0] FW_W  = 2'd3;

    // E-stage operand select
    localparam logic [1:0] FWE_DE = 2'd0;
    localparam logic [1:0] FWE_M  = 2'd1;
    localparam logic [1:0] FWE_W  = 2'd2;

    localparam logic [1:0] TUSE_D    = 2'd0;
    localparam logic [1:0] TUSE_E    = 2'd1;
    localparam logic [1:0] TUSE_M    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_JAL  = 2'd1;
    localparam logic [1:0] TNEW_ALU  = 2'd2;
    localparam logic [1:0] TNEW_LOAD = 2'd3;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int MDCNT_W      = 4;

    typedef struct packed {
        logic       wr;
        logic [4:0] addr;
        logic [1:0] tnew;
    } stage_t;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide unit busy tracker: loads the operation latency when a
// mult/div leaves D and counts down to idle.
module md_busy_counter
    import mips_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);

    localparam logic [MDCNT_W-1:0] LP_MULT = MDCNT_W'(MULT_CYC);
    localparam logic [MDCNT_W-1:0] LP_DIV  = MDCNT_W'(DIV_CYC);

    logic [MDCNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_div ? LP_DIV : LP_MULT;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the five-stage MIPS pipeline: keeps a
// shadow of E/M/W destinations and Tnew, and derives stall, bubble and muxes.
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A_rsD,
    input  logic [4:0] A_rtD,
    input  logic [1:0] TuseRsD,
    input  logic [1:0] TuseRtD,
    input  logic [4:0] AwriteD,
    input  logic       RegWriteD,
    input  logic [1:0] TnewD,
    input  logic       md_startD,
    input  logic       md_divD,
    input  logic       md_useD,
    output logic       stall,
    output logic       clrE,
    output logic [1:0] ForwardRsD,
    output logic [1:0] ForwardRtD,
    output logic [1:0] ForwardRsE,
    output logic [1:0] ForwardRtE
);

    stage_t     r_E;
    stage_t     r_M;
    logic [4:0] r_rsE;
    logic [4:0] r_rtE;
    // W keeps no Tnew: it has always reached 0 by the time an entry gets there
    logic       r_wrW;
    logic [4:0] r_addrW;

    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_md_busy;
    logic       w_md_stall;
    logic       w_stall;
    logic       w_md_start;

    function automatic logic hit(input logic wr, input logic [4:0] addr,
                                 input logic [4:0] src);
        return wr && (addr != 5'd0) && (addr == src);
    endfunction

    function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse,
                                       input stage_t e, input stage_t m);
        logic w_res;
        w_res = 1'b0;
        if (tuse != TUSE_NONE) begin
            if (hit(e.wr, e.addr, src) && (e.tnew > tuse)) w_res = 1'b1;
            if (hit(m.wr, m.addr, src) && (m.tnew > tuse)) w_res = 1'b1;
        end
        return w_res;
    endfunction

    function automatic logic [1:0] fwd_d(input logic [4:0] src, input stage_t e,
                                         input stage_t m, input logic wr_w,
                                         input logic [4:0] addr_w);
        if (hit(e.wr, e.addr, src) && (e.tnew == 2'd0)) return FW_E;
        if (hit(m.wr, m.addr, src) && (m.tnew == 2'd0)) return FW_M;
        if (hit(wr_w, addr_w, src))                     return FW_W;
        return FW_RF;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] src, input stage_t m,
                                         input logic wr_w, input logic [4:0] addr_w);
        if (hit(m.wr, m.addr, src) && (m.tnew == 2'd0)) return FWE_M;
        if (hit(wr_w, addr_w, src))                     return FWE_W;
        return FWE_DE;
    endfunction

    always_comb begin
        w_stall_rs = src_stall(A_rsD, TuseRsD, r_E, r_M);
        w_stall_rt = src_stall(A_rtD, TuseRtD, r_E, r_M);
        w_md_stall = md_useD && w_md_busy;
        w_stall    = w_stall_rs || w_stall_rt || w_md_stall;
        w_md_start = md_startD && !w_stall;
    end

    assign stall      = w_stall;
    assign clrE       = w_stall;
    assign ForwardRsD = fwd_d(A_rsD, r_E, r_M, r_wrW, r_addrW);
    assign ForwardRtD = fwd_d(A_rtD, r_E, r_M, r_wrW, r_addrW);
    assign ForwardRsE = fwd_e(r_rsE, r_M, r_wrW, r_addrW);
    assign ForwardRtE = fwd_e(r_rtE, r_M, r_wrW, r_addrW);

    // A stalled D inserts a bubble into E; M and W always advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_E     <= '0;
            r_M     <= '0;
            r_rsE   <= 5'd0;
            r_rtE   <= 5'd0;
            r_wrW   <= 1'b0;
            r_addrW <= 5'd0;
        end else begin
            if (w_stall) begin
                r_E   <= '0;
                r_rsE <= 5'd0;
                r_rtE <= 5'd0;
            end else begin
                r_E   <= '{wr: RegWriteD, addr: AwriteD, tnew: tnew_dec(TnewD)};
                r_rsE <= A_rsD;
                r_rtE <= A_rtD;
            end
            r_M     <= '{wr: r_E.wr, addr: r_E.addr, tnew: tnew_dec(r_E.tnew)};
            r_wrW   <= r_M.wr;
            r_addrW <= r_M.addr;
        end
    end

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy (
        .clk     (clk),
        .rst_n   (reset),
        .i_start (w_md_start),
        .i_div   (md_divD),
        .o_busy  (w_md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized bench for hazard_scoreboard against an
// instruction-age reference model of the pipeline.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] A_rsD, A_rtD, AwriteD;
    logic [1:0] TuseRsD, TuseRtD, TnewD;
    logic       RegWriteD, md_startD, md_divD, md_useD;
    logic       stall, clrE;
    logic [1:0] ForwardRsD, ForwardRtD, ForwardRsE, ForwardRtE;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .A_rsD      (A_rsD),
        .A_rtD      (A_rtD),
        .TuseRsD    (TuseRsD),
        .TuseRtD    (TuseRtD),
        .AwriteD    (AwriteD),
        .RegWriteD  (RegWriteD),
        .TnewD      (TnewD),
        .md_startD  (md_startD),
        .md_divD    (md_divD),
        .md_useD    (md_useD),
        .stall      (stall),
        .clrE       (clrE),
        .ForwardRsD (ForwardRsD),
        .ForwardRtD (ForwardRtD),
        .ForwardRsE (ForwardRsE),
        .ForwardRtE (ForwardRtE)
    );

    // Reference model: pipe[k] is the instruction that left D k+1 edges ago;
    // its remaining latency is its original TnewD minus its age.
    typedef struct {
        bit wr;
        int dst;
        int rs;
        int rt;
        int tnewD;
    } instr_t;

    instr_t pipe [3];
    int     cyc;
    bit     md_valid;
    int     md_t;
    int     md_n;
    int     checks = 0;
    int     failures = 0;

    function automatic int remaining(int k);
        int r;
        r = pipe[k].tnewD - 1 - k;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit writes(int k, int src);
        return pipe[k].wr && (pipe[k].dst != 0) && (pipe[k].dst == src);
    endfunction

    function automatic bit m_md_busy();
        return md_valid && ((cyc - md_t) < md_n);
    endfunction

    function automatic bit m_src_stall(int src, int tuse);
        if (tuse == 3) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (writes(k, src) && remaining(k) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return m_src_stall(int'(A_rsD), int'(TuseRsD)) ||
               m_src_stall(int'(A_rtD), int'(TuseRtD)) ||
               (md_useD && m_md_busy());
    endfunction

    function automatic int m_fwd_d(int src);
        for (int k = 0; k < 3; k++)
            if (writes(k, src) && (k == 2 || remaining(k) == 0)) return k + 1;
        return 0;
    endfunction

    function automatic int m_fwd_e(int src);
        for (int k = 1; k < 3; k++)
            if (writes(k, src) && (k == 2 || remaining(k) == 0)) return k;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_stall"}, 8'(stall), 8'(m_stall()));
        chk({tag, "_clrE"},  8'(clrE),  8'(m_stall()));
        chk({tag, "_fwdRsD"}, 8'(ForwardRsD), 8'(m_fwd_d(int'(A_rsD))));
        chk({tag, "_fwdRtD"}, 8'(ForwardRtD), 8'(m_fwd_d(int'(A_rtD))));
        chk({tag, "_fwdRsE"}, 8'(ForwardRsE), 8'(m_fwd_e(pipe[0].rs)));
        chk({tag, "_fwdRtE"}, 8'(ForwardRtE), 8'(m_fwd_e(pipe[0].rt)));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{wr: 1'b0, dst: 0, rs: 0, rt: 0, tnewD: 0};
        cyc = 0;
        md_valid = 1'b0;
        md_t = 0;
        md_n = 0;
    endtask

    task automatic set_d(input int rs, input int rt, input int urs, input int urt,
                         input int aw, input int wr, input int tn,
                         input int ms, input int md, input int mu);
        A_rsD = 5'(rs); A_rtD = 5'(rt);
        TuseRsD = 2'(urs); TuseRtD = 2'(urt);
        AwriteD = 5'(aw); RegWriteD = 1'(wr); TnewD = 2'(tn);
        md_startD = 1'(ms); md_divD = 1'(md); md_useD = 1'(mu);
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        #3;
    endtask

    // Advance one clock; the model commits the decision seen before the edge.
    task automatic tick();
        bit     st;
        instr_t d;
        st = m_stall();
        d  = '{wr: RegWriteD, dst: int'(AwriteD), rs: int'(A_rsD), rt: int'(A_rtD),
               tnewD: int'(TnewD)};
        @(posedge clk);
        if (reset) begin
            cyc++;
            if (md_startD && !st) begin
                md_valid = 1'b1;
                md_t = cyc;
                md_n = md_divD ? 10 : 5;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = st ? '{wr: 1'b0, dst: 0, rs: 0, rt: 0, tnewD: 0} : d;
        end
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) begin
            nop(); settle(); check_all("flush"); tick();
        end
    endtask

    initial begin
        int n;
        model_reset();
        reset = 1'b1;
        set_d(1, 2, 0, 0, 1, 1, 3, 1, 1, 1);
        #1 reset = 1'b0;
        #1;
        chk("reset_stall", 8'(stall), 8'd0);
        chk("reset_clrE", 8'(clrE), 8'd0);
        chk("reset_fwdRsD", 8'(ForwardRsD), 8'd0);
        chk("reset_fwdRtE", 8'(ForwardRtE), 8'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        flush();

        // lw $1 then add $2,$1,$3
        set_d(0, 0, 3, 3, 1, 1, 3, 0, 0, 0); settle(); check_all("lw"); tick();
        set_d(1, 3, 1, 1, 2, 1, 2, 0, 0, 0); settle(); check_all("lwadd");
        chk("lw_use_stall", 8'(stall), 8'd1);
        chk("lw_use_clrE", 8'(clrE), 8'd1);
        tick(); settle(); check_all("lwadd2");
        chk("lw_use_release", 8'(stall), 8'd0);
        tick(); nop(); settle(); check_all("lwadd3");
        chk("lw_use_fwdRsE_W", 8'(ForwardRsE), 8'd2);
        tick(); flush();

        // add $1 then beq $1,$0
        set_d(0, 0, 3, 3, 1, 1, 2, 0, 0, 0); settle(); check_all("add"); tick();
        set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle(); check_all("beq");
        chk("beq_stall", 8'(stall), 8'd1);
        tick(); settle(); check_all("beq2");
        chk("beq_release", 8'(stall), 8'd0);
        chk("beq_fwdRsD_M", 8'(ForwardRsD), 8'd2);
        tick(); flush();

        // jal $31 then jr $31
        set_d(0, 0, 3, 3, 31, 1, 1, 0, 0, 0); settle(); check_all("jal"); tick();
        set_d(31, 0, 0, 3, 0, 0, 0, 0, 0, 0); settle(); check_all("jr");
        chk("jr_stall", 8'(stall), 8'd0);
        chk("jr_fwdRsD_E", 8'(ForwardRsD), 8'd1);
        tick(); flush();

        // add $5, ori $5, sub using $5
        set_d(0, 0, 3, 3, 5, 1, 2, 0, 0, 0); settle(); check_all("add5"); tick();
        set_d(0, 0, 3, 3, 5, 1, 2, 0, 0, 0); settle(); check_all("ori5"); tick();
        set_d(5, 0, 1, 3, 6, 1, 2, 0, 0, 0); settle(); check_all("sub5");
        chk("sub5_stall", 8'(stall), 8'd0);
        tick(); nop(); settle(); check_all("sub5e");
        chk("sub5_fwdRsE_M", 8'(ForwardRsE), 8'd1);
        tick(); flush();

        // div then mflo, mult then mflo
        for (int pass = 0; pass < 2; pass++) begin
            set_d(2, 3, 1, 1, 0, 0, 0, 1, (pass == 0) ? 1 : 0, 1);
            settle(); check_all("mdstart"); tick();
            set_d(0, 0, 3, 3, 4, 1, 2, 0, 0, 1);
            n = 0;
            settle(); check_all("mdwait");
            while (stall === 1'b1 && n < 30) begin
                tick(); n++; settle(); check_all("mdwait");
            end
            chk((pass == 0) ? "div_stall_cycles" : "mult_stall_cycles",
                8'(n), (pass == 0) ? 8'd10 : 8'd5);
            tick(); flush();
        end

        // lw $0 then use of $0
        set_d(0, 0, 3, 3, 0, 1, 3, 0, 0, 0); settle(); check_all("lw0"); tick();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle(); check_all("use0");
        chk("zero_stall", 8'(stall), 8'd0);
        chk("zero_fwdRsD", 8'(ForwardRsD), 8'd0);
        tick(); nop(); settle(); check_all("use0e");
        chk("zero_fwdRsE", 8'(ForwardRsE), 8'd0);
        tick(); flush();

        // reset asserted while stalled
        set_d(0, 0, 3, 3, 7, 1, 3, 0, 0, 0); settle(); check_all("lw7"); tick();
        set_d(7, 0, 0, 3, 0, 0, 0, 0, 0, 0); settle(); check_all("beq7");
        chk("prereset_stall", 8'(stall), 8'd1);
        reset = 1'b0;
        #1;
        chk("midreset_stall", 8'(stall), 8'd0);
        chk("midreset_clrE", 8'(clrE), 8'd0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        settle(); check_all("postreset");
        chk("postreset_stall", 8'(stall), 8'd0);
        chk("postreset_fwdRsD", 8'(ForwardRsD), 8'd0);
        tick(); nop(); settle(); check_all("postreset2");
        chk("postreset_fwdRsE", 8'(ForwardRsE), 8'd0);
        tick(); flush();

        // randomized instruction stream; D is held while stalled
        for (int i = 0; i < 600; i++) begin
            if (!m_stall()) begin
                int ms;
                ms = ($urandom_range(0, 11) == 0) ? 1 : 0;
                set_d($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 1),
                      $urandom_range(0, 3), ms, $urandom_range(0, 1),
                      (ms == 1 || $urandom_range(0, 5) == 0) ? 1 : 0);
            end
            settle(); check_all("rnd"); tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Hazard and forwarding controller for the five-stage MIPS pipeline. It consumes the decode-stage view of each instruction and drives the D/E pipeline register's `clr`, the F/D stall, and all forwarding mux selects. It keeps its own registered shadow of the E, M and W stages (destination, Tnew, write enable, sources) plus a multiply/divide busy counter. This makes stall and forward decisions self-contained and cycle-accurate with the datapath registers.

## Interface
Parameters:
- `MULT_CYC`, 5, busy cycles after a mult/multu enters E
- `DIV_CYC`, 10, busy cycles after a div/divu enters E

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `A_rsD`, `A_rtD`  in  5 each  source register numbers in D
- `TuseRsD`, `TuseRtD`  in  2 each  cycles from D until the operand is consumed (0 = D, 1 = E, 2 = M); 3 = unused
- `AwriteD`  in  5  destination register of the D instruction
- `RegWriteD`  in  1  D instruction writes the GRF
- `TnewD`  in  2  cycles from D until the result exists (R-type 2, lw 3, jal 1)
- `md_startD`  in  1  D is mult/multu/div/divu
- `md_divD`  in  1  with `md_startD`, selects `DIV_CYC`
- `md_useD`  in  1  D is mfhi/mflo/mthi/mtlo/mult/div
- `stall`  out  1  hold PC and F/D register
- `clrE`  out  1  insert a bubble into D/E; always equal to `stall`
- `ForwardRsD`, `ForwardRtD`  out  2 each  D operand select: 0 GRF, 1 E, 2 M, 3 W
- `ForwardRsE`, `ForwardRtE`  out  2 each  E operand select: 0 D/E value, 1 M, 2 W

## Operation
- Shadow entry per stage X ∈ {E, M, W}: `addrX`, `TnewX`, `wrX`. E also holds `rsE` and `rtE`. A match requires `wrX`, `addrX != 0`, and `addrX` equal to the source.
- Advance per clock:
  - If not stalled, E loads the D fields with Tnew = sat(TnewD-1).
  - If stalled, E loads a bubble: all fields 0.
  - M loads E with sat(TnewE-1); W loads M with sat(TnewM-1).
  - sat(x-1) saturates at 0.
- Data stall for each used source (Tuse ≠ 3): stall if a matching E entry has `TnewE > Tuse`, or a matching M entry has `TnewM > Tuse`.
- MD stall: `md_useD && mdcnt != 0`.
- `stall` is the OR of the rs data stall, the rt data stall and the MD stall.
- D forwarding: priority E > M > W.
  - Select E only on a match with TnewE == 0; select M on a match with TnewM == 0; select W on any match.
  - Otherwise select 0.
- E forwarding: uses `rsE`/`rtE`; M with TnewM == 0 has priority over W; otherwise 0.
- MD counter `mdcnt` (4 bits):
  - On an edge with `md_startD && !stall`, load `DIV_CYC` if `md_divD`, else `MULT_CYC`.
  - Otherwise decrement while nonzero.
  - A start while `mdcnt != 0` is impossible, because `md_useD` covers starts and forces a stall.

## Timing
- All outputs are combinational from registered state and the current D inputs. There is no added latency.
- Reset: every shadow field and `mdcnt` go to 0. Outputs are therefore `stall=0`, `clrE=0`, all Forward = 0, independent of the D inputs except for the data-stall terms, which are 0 because no entry matches.
- A reset deassertion mid-operation restarts from an empty pipeline.
- A stall persists until the blocking Tnew decrements; the D inputs are held by the stalled F/D register.
- Register $0 is never stalled on and never forwarded.
- MD: a start entering E at edge t gives busy for cycles t..t+N-1. A dependent instruction leaves D at edge t+N.

## Structure
- Shared package (`mips_pkg`) holds:
  - forward select encodings (FW_RF, FW_E, FW_M, FW_W)
  - Tuse/Tnew constants, with TUSE_NONE = 3
  - `MULT_CYC`/`DIV_CYC` defaults
- Sub-module `md_busy_counter` contains the counter, load and busy output.
- The stage shadow and the decision logic stay in the top module.

## Test plan
- lw $1 (TnewD 3) then add $2,$1,$3 (TuseRs 1):
  - 1 cycle `stall`/`clrE`=1.
  - Next cycle stall 0.
  - The cycle after, `ForwardRsE`=2 (W).
- add $1 (TnewD 2) then beq $1,$0 (TuseRs 0):
  - Stall 1 cycle.
  - Then `ForwardRsD`=2 (M).
- jal $31 (TnewD 1) then jr $31 (Tuse 0): no stall, `ForwardRsD`=1 (E).
- Back-to-back writes to $5 (add, then ori), followed by sub using $5 at E: `ForwardRsE`=1 from the newer M entry, not W.
- div then mflo:
  - `stall`=1 for exactly 10 cycles after div enters E.
  - With mult, 5 cycles.
- Destination $0 with lw then use of $0: stall 0, Forward 0.
- Reset asserted mid-stall: `stall` drops immediately and all shadows are empty after release.
